// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive sequencer for a full-speed USB receiver.
// Watches for packet start, validates the SYNC byte and frames data bytes
// from bit-sample strobes. It raises a FIFO write pulse for each stored byte,
// keeps a per-packet byte count and holds a sticky receive-error flag.
module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [6:0] byte_count
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CHK_SYNC,
    RECV,
    STORE,
    EOP_WAIT,
    ERR_WAIT
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_byte_count;
  logic       r_rcving;
  logic       r_w_enable;
  logic       r_err;

  logic w_byte_done;
  logic w_count_full;
  logic w_line_idle;
  logic w_state_change;
  logic w_enter_sync;
  logic w_enter_idle;
  logic w_enter_err;

  // eop has priority over a coincident bit strobe, so it can never complete a byte.
  assign w_byte_done    = shift_enable && (r_bit_cnt == 3'd7) && !eop;
  assign w_count_full   = (r_byte_count == MAX_CNT);
  // The bus is back at J once a transition is seen with SE0 gone.
  assign w_line_idle    = d_edge && !eop;
  assign w_state_change = (w_state_next != r_state);
  assign w_enter_sync   = (w_state_next == SYNC) && (r_state != SYNC);
  assign w_enter_idle   = (w_state_next == IDLE) && (r_state != IDLE);
  assign w_enter_err    = (w_state_next == ERR_WAIT) && (r_state != ERR_WAIT);

  // Next-state decode; stray d_edge pulses mid-packet fall through to the default hold.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (d_edge) w_state_next = SYNC;
      end
      SYNC: begin
        if (eop)              w_state_next = ERR_WAIT;
        else if (w_byte_done) w_state_next = CHK_SYNC;
      end
      CHK_SYNC: begin
        w_state_next = (rcv_data == SYNC_BYTE) ? RECV : ERR_WAIT;
      end
      RECV: begin
        if (eop) begin
          // A clean end needs a byte boundary and at least one stored byte;
          // at a boundary the end is taken on the next bit strobe.
          if (shift_enable && (r_bit_cnt == 3'd0) && (r_byte_count != 7'd0))
            w_state_next = EOP_WAIT;
          else if ((r_bit_cnt != 3'd0) || (r_byte_count == 7'd0))
            w_state_next = ERR_WAIT;
        end else if (w_byte_done) begin
          w_state_next = STORE;
        end
      end
      STORE: begin
        w_state_next = w_count_full ? ERR_WAIT : RECV;
      end
      EOP_WAIT, ERR_WAIT: begin
        if (w_line_idle) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Bit position within the current byte; restarts on every state entry.
  always_ff @(posedge clk) begin
    if (rst)
      r_bit_cnt <= 3'd0;
    else if (w_state_change)
      r_bit_cnt <= 3'd0;
    else if (shift_enable && ((r_state == SYNC) || (r_state == RECV)))
      r_bit_cnt <= r_bit_cnt + 3'd1;
  end

  // Byte count: cleared at packet start, bumped as STORE commits a byte, never wraps.
  always_ff @(posedge clk) begin
    if (rst)
      r_byte_count <= 7'd0;
    else if (w_enter_sync)
      r_byte_count <= 7'd0;
    else if ((r_state == STORE) && !w_count_full)
      r_byte_count <= r_byte_count + 7'd1;
  end

  // FIFO write strobe is registered from the next state, so it is high exactly while in STORE.
  always_ff @(posedge clk) begin
    if (rst) r_w_enable <= 1'b0;
    else     r_w_enable <= (w_state_next == STORE) && !w_count_full;
  end

  // Receiving flag spans packet start to the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst)               r_rcving <= 1'b0;
    else if (w_enter_sync) r_rcving <= 1'b1;
    else if (w_enter_idle) r_rcving <= 1'b0;
  end

  // Sticky error: set on entering ERR_WAIT, survives IDLE, cleared by the next packet.
  always_ff @(posedge clk) begin
    if (rst)               r_err <= 1'b0;
    else if (w_enter_sync) r_err <= 1'b0;
    else if (w_enter_err)  r_err <= 1'b1;
  end

  assign rcving     = r_rcving;
  assign w_enable   = r_w_enable;
  assign r_error    = r_err;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed packets against a packet-level model of the receiver.
// The model tracks phase (idle / hunting SYNC / data / waiting for J), bits in the
// current byte, byte count, rcving and error; FIFO writes are scheduled as the
// clock edge on which the byte-completing strobe is sampled.
module tb_usb_rx_ctrl;

  localparam logic [7:0] SYNC_VAL = 8'h80;
  localparam int         MAXB     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_edge;
  logic       shift_enable;
  logic       eop;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [6:0] byte_count;

  usb_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .d_edge       (d_edge),
    .shift_enable (shift_enable),
    .eop          (eop),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state (written only by the stimulus process).
  int   m_phase = 0;   // 0 idle, 1 hunting SYNC, 2 data, 3 waiting for J
  int   m_bits  = 0;
  int   m_count = 0;
  bit   m_rcving = 0;
  bit   m_error  = 0;
  int   wq[$];         // edges after which w_enable must be high

  bit    run     = 0;
  bit    settled = 0;
  bit    pin_req = 0;
  string pin_name;
  bit    pin_rcv;
  bit    pin_err;
  int    pin_cnt;
  int    pin_we;
  int    pin_we_base;

  int n_cmp = 0;
  int n_bad = 0;
  int we_seen = 0;

  // Single compare process: w_enable every cycle, other outputs when settled, literal pins on request.
  initial begin
    int  rd_idx;
    bit  exp_we;
    rd_idx = 0;
    forever begin
      @(negedge clk);
      if (run) begin
        exp_we = 1'b0;
        if (rd_idx < wq.size() && wq[rd_idx] == cyc) begin
          exp_we = 1'b1;
          rd_idx++;
        end
        n_cmp++;
        if (w_enable !== exp_we) begin
          n_bad++;
          $display("FAIL w_enable @cyc %0d: got %b expected %b", cyc, w_enable, exp_we);
        end
        if (w_enable === 1'b1) we_seen++;
        if (settled) begin
          n_cmp += 3;
          if (rcving !== m_rcving) begin
            n_bad++;
            $display("FAIL rcving @cyc %0d: got %b expected %b", cyc, rcving, m_rcving);
          end
          if (r_error !== m_error) begin
            n_bad++;
            $display("FAIL r_error @cyc %0d: got %b expected %b", cyc, r_error, m_error);
          end
          if (byte_count !== 7'(m_count)) begin
            n_bad++;
            $display("FAIL byte_count @cyc %0d: got %0d expected %0d", cyc, byte_count, m_count);
          end
        end
        if (pin_req) begin
          n_cmp += 4;
          if (rcving !== pin_rcv) begin
            n_bad++;
            $display("FAIL %s rcving: got %b expected %b", pin_name, rcving, pin_rcv);
          end
          if (r_error !== pin_err) begin
            n_bad++;
            $display("FAIL %s r_error: got %b expected %b", pin_name, r_error, pin_err);
          end
          if (byte_count !== 7'(pin_cnt)) begin
            n_bad++;
            $display("FAIL %s byte_count: got %0d expected %0d", pin_name, byte_count, pin_cnt);
          end
          if ((we_seen - pin_we_base) != pin_we) begin
            n_bad++;
            $display("FAIL %s writes: got %0d expected %0d", pin_name, we_seen - pin_we_base, pin_we);
          end
        end
      end
    end
  end

  // One clock of stimulus; chk marks the upcoming negedge as a settled point.
  task automatic step(input logic de, input logic se, input logic e, input bit chk);
    d_edge = de; shift_enable = se; eop = e; settled = chk;
    @(posedge clk);
    #1;
  endtask

  task automatic model_bit();
    if (m_phase == 1 || m_phase == 2) begin
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (m_phase == 1) begin
          if (rcv_data == SYNC_VAL) m_phase = 2;
          else begin m_phase = 3; m_error = 1; end
        end else if (m_count == MAXB) begin
          m_phase = 3; m_error = 1;
        end else begin
          wq.push_back(cyc);
          m_count++;
        end
      end
    end
  endtask

  task automatic model_eop(input bit se);
    if (m_phase == 1) begin
      m_phase = 3; m_error = 1;
    end else if (m_phase == 2) begin
      if (m_bits != 0 || m_count == 0) begin
        m_phase = 3; m_error = 1;
      end else if (se) begin
        m_phase = 3;
      end
    end
  endtask

  task automatic model_dedge();
    if (m_phase == 0) begin
      m_phase = 1; m_rcving = 1; m_error = 0; m_count = 0; m_bits = 0;
    end else if (m_phase == 3) begin
      m_phase = 0; m_rcving = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    rcv_data = {b, rcv_data[7:1]};
    step(1'b0, 1'b1, 1'b0, 1'b1);
    model_bit();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  // SE0 for four clocks with one bit strobe on the first or second; a d_edge during SE0 must be ignored.
  task automatic send_eop(input bit se_first);
    step(1'b0, se_first, 1'b1, 1'b1);
    model_eop(se_first);
    step(1'b0, !se_first, 1'b1, 1'b1);
    model_eop(!se_first);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_dedge();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    model_dedge();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pin(input string nm, input bit rv, input bit er, input int cnt, input int we);
    pin_name = nm; pin_rcv = rv; pin_err = er; pin_cnt = cnt; pin_we = we;
    pin_req = 1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pin_req = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    m_phase = 0; m_bits = 0; m_count = 0; m_rcving = 0; m_error = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; d_edge = 1'b0; shift_enable = 1'b0; eop = 1'b0; rcv_data = 8'h00;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    run = 1;
    pin_we_base = we_seen;
    pin("reset", 1'b0, 1'b0, 0, 0);

    // Good packet: SYNC, A5, 3C, clean end, then back to J.
    pin_we_base = we_seen;
    send_dedge();
    send_byte(8'h80);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_eop(1'b0);
    pin("good_eop_wait", 1'b1, 1'b0, 2, 2);
    send_dedge();
    pin("good_idle", 1'b0, 1'b0, 2, 2);

    // Bad SYNC value: error, sticky through IDLE, cleared on the next start.
    pin_we_base = we_seen;
    send_dedge();
    send_byte(8'h81);
    pin("bad_sync", 1'b1, 1'b1, 0, 0);
    send_dedge();
    pin("bad_sync_idle", 1'b0, 1'b1, 0, 0);
    send_dedge();
    pin("next_start", 1'b1, 1'b0, 0, 0);
    send_eop(1'b0);
    pin("eop_in_sync", 1'b1, 1'b1, 0, 0);
    send_dedge();

    // eop after three data bits.
    pin_we_base = we_seen;
    send_dedge();
    send_byte(8'h80);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_eop(1'b0);
    pin("short_byte", 1'b1, 1'b1, 0, 0);
    send_dedge();

    // Overflow: MAXB+1 bytes.
    send_dedge();
    send_byte(8'h80);
    pin_we_base = we_seen;
    for (int k = 0; k <= MAXB; k++) send_byte(8'(k * 37 + 5));
    pin("overflow", 1'b1, 1'b1, 64, 64);
    send_eop(1'b0);
    send_dedge();

    // Bit strobe coincident with eop at the last bit of a byte.
    send_dedge();
    send_byte(8'h80);
    pin_we_base = we_seen;
    send_byte(8'h5A);
    for (int k = 0; k < 7; k++) send_bit(k[0]);
    send_eop(1'b1);
    pin("se_with_eop", 1'b1, 1'b1, 1, 1);
    send_dedge();

    // Reset mid-packet, then a short good packet.
    send_dedge();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    do_reset();
    pin_we_base = we_seen;
    pin("mid_reset", 1'b0, 1'b0, 0, 0);
    send_dedge();
    send_byte(8'h80);
    send_byte(8'h0F);
    send_eop(1'b1);
    send_dedge();
    pin("after_reset_pkt", 1'b0, 1'b0, 1, 1);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
